// File: rtl/fetch_fusion_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fusion_queue
//  Description : Fetch-side instruction queue (circular buffer) that inspects
//                the two oldest entries and flags macro-op fusion candidates
//                (LUI+ADDI, AUIPC+JALR, LOAD+ALU). Fused pairs of types 01/10
//                retire two entries per handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fusion_queue #(
    parameter int          DEPTH       = 4,
    parameter logic [2:0]  FUSION_MASK = 3'b111,
    parameter int          CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [31:0]              in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst0,
    output logic [31:0]              out_inst1,
    output logic [31:0]              out_pc,
    output logic                     out_fused,
    output logic [1:0]               out_fuse_type,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         fuse_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [31:0]      inst_mem_q [DEPTH];
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [c_AW-1:0]  head_q, head_d;
    logic [c_AW-1:0]  tail_q, tail_d;
    logic [c_CW-1:0]  count_q, count_d;
    logic [CNT_W-1:0] fuse_cnt_q, fuse_cnt_d;

    logic [c_AW-1:0]  w_head1;
    logic             w_two;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_pop_amt;
    logic [1:0]       w_fuse_type;
    logic [31:0]      w_inst0;
    logic [31:0]      w_inst1;

    // Head+1 wraps naturally because DEPTH is a power of two.
    assign w_head1   = head_q + 1'b1;
    assign w_two     = (count_q >= c_CW'(2));
    assign w_inst0   = inst_mem_q[head_q];
    assign w_inst1   = w_two ? inst_mem_q[w_head1] : 32'h0;

    // Ready depends only on stored occupancy, never on a same-cycle pop.
    assign in_ready  = (count_q < c_CW'(DEPTH));
    assign w_push    = in_valid && in_ready && !flush;
    assign out_valid = (count_q != '0);
    assign w_pop     = out_valid && out_ready && !flush;

    assign out_inst0     = w_inst0;
    assign out_inst1     = w_inst1;
    assign out_pc        = pc_mem_q[head_q];
    assign out_fuse_type = w_fuse_type;
    assign out_fused     = (w_fuse_type != 2'b00);
    assign count         = count_q;
    assign fuse_cnt      = fuse_cnt_q;

    // Fusion pattern decode on the two oldest entries; inst0 opcode selects the pattern.
    always_comb begin
        w_fuse_type = 2'b00;
        if (w_two && (w_inst0[11:7] != 5'd0)) begin
            case (w_inst0[6:0])
                7'b0110111: begin
                    if (FUSION_MASK[0] && (w_inst1[6:0] == 7'b0010011) &&
                        (w_inst1[14:12] == 3'b000) && (w_inst0[11:7] == w_inst1[19:15]))
                        w_fuse_type = 2'b01;
                end
                7'b0010111: begin
                    if (FUSION_MASK[1] && (w_inst1[6:0] == 7'b1100111) &&
                        (w_inst1[14:12] == 3'b000) && (w_inst0[11:7] == w_inst1[19:15]))
                        w_fuse_type = 2'b10;
                end
                7'b0000011: begin
                    // rs2 only exists for the register-register ALU form.
                    if (FUSION_MASK[2] &&
                        (((w_inst1[6:0] == 7'b0110011) &&
                          ((w_inst0[11:7] == w_inst1[19:15]) || (w_inst0[11:7] == w_inst1[24:20]))) ||
                         ((w_inst1[6:0] == 7'b0010011) && (w_inst0[11:7] == w_inst1[19:15]))))
                        w_fuse_type = 2'b11;
                end
                default: w_fuse_type = 2'b00;
            endcase
        end
    end

    // Type 01/10 consume both entries; LOAD+ALU is only a hint and pops one.
    always_comb begin
        w_pop_amt = 2'd0;
        if (w_pop)
            w_pop_amt = ((w_fuse_type == 2'b01) || (w_fuse_type == 2'b10)) ? 2'd2 : 2'd1;
    end

    // Next-state for pointers, occupancy and the saturating fusion counter.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fuse_cnt_d = fuse_cnt_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push)
                tail_d = tail_q + 1'b1;
            head_d  = head_q + c_AW'(w_pop_amt);
            count_d = count_q + c_CW'(w_push) - c_CW'(w_pop_amt);
            if (w_pop && (w_fuse_type != 2'b00) && (fuse_cnt_q != '1))
                fuse_cnt_d = fuse_cnt_q + 1'b1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fuse_cnt_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fuse_cnt_q <= fuse_cnt_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            inst_mem_q[tail_q] <= in_inst;
            pc_mem_q[tail_q]   <= in_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_fusion_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_fusion_queue
//  Description : Directed self-checking bench for fetch_fusion_queue. Issued
//                head entries are compared by a monitor against a scoreboard
//                of hand-computed expected issues; occupancy, ready and
//                statistics are checked inline.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_fusion_queue;

    localparam int         DEPTH = 4;
    localparam int         CNT_W = 4;
    localparam logic [2:0] FMASK = 3'b101;

    localparam logic [31:0] LUI_X1  = 32'h123450B7;
    localparam logic [31:0] ADDI_X1 = 32'h67808093;
    localparam logic [31:0] AUIPC   = 32'h00000297;
    localparam logic [31:0] JALR    = 32'h000280E7;
    localparam logic [31:0] LW_X2   = 32'h0000A103;
    localparam logic [31:0] ADD_X3  = 32'h002081B3;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_inst;
    logic [31:0]            in_pc;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            out_inst0;
    logic [31:0]            out_inst1;
    logic [31:0]            out_pc;
    logic                   out_fused;
    logic [1:0]             out_fuse_type;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]       fuse_cnt;

    typedef struct packed {
        logic [31:0] i0;
        logic [31:0] i1;
        logic [31:0] pc;
        logic [1:0]  ft;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    fetch_fusion_queue #(
        .DEPTH       (DEPTH),
        .FUSION_MASK (FMASK),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst0     (out_inst0),
        .out_inst1     (out_inst1),
        .out_pc        (out_pc),
        .out_fused     (out_fused),
        .out_fuse_type (out_fuse_type),
        .count         (count),
        .fuse_cnt      (fuse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_issue(input logic [31:0] i0, input logic [31:0] i1,
                                input logic [31:0] pc, input logic [1:0] ft);
        exp_t e;
        e.i0 = i0;
        e.i1 = i1;
        e.pc = pc;
        e.ft = ft;
        sb.push_back(e);
    endtask

    task automatic pop_n(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        out_ready = 1'b0;
    endtask

    // Monitor: every accepted head issue is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_issue: got inst0 %h expected no issue at %0t", out_inst0, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("issue_inst0", out_inst0, mon_e.i0);
                chk("issue_inst1", out_inst1, mon_e.i1);
                chk("issue_pc", out_pc, mon_e.pc);
                chk("issue_fuse_type", 32'(out_fuse_type), 32'(mon_e.ft));
            end
        end
    end

    // Time bound so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] w [7];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) w[i] = 32'h00000013 | (32'(i) << 20);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_fused", 32'(out_fused), 0);
        chk("rst_fuse_type", 32'(out_fuse_type), 0);
        chk("rst_fuse_cnt", 32'(fuse_cnt), 0);

        // LUI+ADDI fuses and pops both entries at once
        push(LUI_X1, 32'h100);
        push(ADDI_X1, 32'h104);
        chk("lui_addi_count", 32'(count), 2);
        chk("lui_addi_type", 32'(out_fuse_type), 1);
        chk("lui_addi_fused", 32'(out_fused), 1);
        expect_issue(LUI_X1, ADDI_X1, 32'h100, 2'b01);
        pop_n(1);
        chk("lui_addi_count_after", 32'(count), 0);
        chk("lui_addi_fuse_cnt", 32'(fuse_cnt), 1);

        // AUIPC+JALR disabled by mask: two single issues
        push(AUIPC, 32'h200);
        push(JALR, 32'h204);
        chk("auipc_jalr_type", 32'(out_fuse_type), 0);
        expect_issue(AUIPC, JALR, 32'h200, 2'b00);
        expect_issue(JALR, 32'h0, 32'h204, 2'b00);
        pop_n(1);
        chk("auipc_jalr_count_mid", 32'(count), 1);
        pop_n(1);
        chk("auipc_jalr_count_after", 32'(count), 0);
        chk("auipc_jalr_fuse_cnt", 32'(fuse_cnt), 1);

        // LOAD+ALU hint (rs2 match): pops one, counted as fused
        push(LW_X2, 32'h300);
        push(ADD_X3, 32'h304);
        chk("load_alu_type", 32'(out_fuse_type), 3);
        expect_issue(LW_X2, ADD_X3, 32'h300, 2'b11);
        pop_n(1);
        chk("load_alu_count", 32'(count), 1);
        chk("load_alu_head", out_inst0, ADD_X3);
        chk("load_alu_head_fused", 32'(out_fused), 0);
        chk("load_alu_fuse_cnt", 32'(fuse_cnt), 2);
        expect_issue(ADD_X3, 32'h0, 32'h304, 2'b00);
        pop_n(1);
        chk("load_alu_count_after", 32'(count), 0);

        // Fill to full with decode stalled; fifth word must be refused
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_inst  = w[i];
            in_pc    = 32'h400 + 32'(4 * i);
            tick();
            if (i == 3) begin
                chk("full_count", 32'(count), 4);
                chk("full_in_ready", 32'(in_ready), 0);
            end
        end
        chk("full_reject_count", 32'(count), 4);
        chk("full_head", out_inst0, w[0]);
        expect_issue(w[0], w[1], 32'h400, 2'b00);
        expect_issue(w[1], w[2], 32'h404, 2'b00);
        out_ready = 1'b1;
        tick();
        chk("full_pop_only_count", 32'(count), 3);
        tick();
        chk("push_pop_count", 32'(count), 3);
        out_ready = 1'b0;
        in_inst   = w[5];
        in_pc     = 32'h414;
        tick();
        in_valid  = 1'b0;
        chk("refill_count", 32'(count), 4);
        chk("refill_in_ready", 32'(in_ready), 0);
        chk("refill_head", out_inst0, w[2]);
        expect_issue(w[2], w[3], 32'h408, 2'b00);
        pop_n(1);
        chk("three_left_count", 32'(count), 3);

        // Flush with concurrent push and pop request
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_inst   = w[6];
        in_pc     = 32'h418;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        chk("flush_fuse_cnt", 32'(fuse_cnt), 2);

        // Single entry issues alone, no second word visible
        push(LUI_X1, 32'h500);
        chk("single_count", 32'(count), 1);
        chk("single_head", out_inst0, LUI_X1);
        chk("single_inst1", out_inst1, 32'h0);
        chk("single_fused", 32'(out_fused), 0);
        expect_issue(LUI_X1, 32'h0, 32'h500, 2'b00);
        pop_n(1);
        chk("single_fuse_cnt", 32'(fuse_cnt), 2);

        // Saturation of the fused-issue counter
        for (int k = 0; k < 19; k++) begin
            expect_issue(LUI_X1, ADDI_X1, 32'h1000 + 32'(8 * k), 2'b01);
            push(LUI_X1, 32'h1000 + 32'(8 * k));
            push(ADDI_X1, 32'h1004 + 32'(8 * k));
            pop_n(1);
            chk("sat_fuse_cnt", 32'(fuse_cnt), (k + 3 > 15) ? 32'd15 : 32'(k + 3));
        end

        // Reset mid-stream overrides a pending push
        push(LUI_X1, 32'h2000);
        push(ADDI_X1, 32'h2004);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_inst  = w[3];
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_fuse_cnt", 32'(fuse_cnt), 0);
        chk("rst_mid_out_valid", 32'(out_valid), 0);
        chk("rst_mid_in_ready", 32'(in_ready), 1);

        tick();
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
